// File: rtl/stack_controller.sv
// Hardware stack controller driving an external single-write, combinational-read stack RAM.
// Two-state control (RUN/FAULT) with sticky overflow/underflow flags cleared by error_clear.
`ifndef WIDTH
`define WIDTH 16
`endif

module stack_controller #(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              active_low_reset,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [`WIDTH-1:0] push_data,
    output logic              op_ready,
    input  logic              error_clear,
    output logic [`WIDTH-1:0] top_data,
    output logic [DEPTH:0]    depth_count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic [DEPTH-1:0]  mem_read_address,
    input  logic [`WIDTH-1:0] mem_read_data,
    output logic              mem_write_enable,
    output logic [DEPTH-1:0]  mem_write_address,
    output logic [`WIDTH-1:0] mem_write_data
);

    typedef enum logic {
        RUN,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

    state_e           state_q, state_d;
    logic [DEPTH:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             write_en;
    logic [DEPTH-1:0] write_addr;
    logic [DEPTH-1:0] top_addr;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CAPACITY);
    assign top_addr = count_q[DEPTH-1:0] - 1'b1;

    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            state_q     <= RUN;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Illegal pushes/pops trap into FAULT without touching the stack contents.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        write_en    = 1'b0;
        write_addr  = count_q[DEPTH-1:0];
        unique case (state_q)
            RUN: begin
                if (op_valid) begin
                    unique case (op_code)
                        OP_PUSH: begin
                            if (is_full) begin
                                overflow_d = 1'b1;
                                state_d    = FAULT;
                            end else begin
                                write_en = 1'b1;
                                count_d  = count_q + 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (is_empty) begin
                                underflow_d = 1'b1;
                                state_d     = FAULT;
                            end else begin
                                count_d = count_q - 1'b1;
                            end
                        end
                        OP_REPLACE: begin
                            if (is_empty) begin
                                underflow_d = 1'b1;
                                state_d     = FAULT;
                            end else begin
                                write_en   = 1'b1;
                                write_addr = top_addr;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FAULT: begin
                if (error_clear) begin
                    state_d     = RUN;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset is folded into the write strobe so an in-flight command never reaches the RAM.
    assign mem_write_enable  = write_en & active_low_reset;
    assign mem_write_address = write_addr;
    assign mem_write_data    = push_data;
    assign mem_read_address  = top_addr;

    assign op_ready    = (state_q == RUN);
    assign depth_count = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign top_data    = is_empty ? '0 : mem_read_data;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: directed scenarios plus randomized traffic
// checked against a queue-based stack model and a behavioural RAM.
`ifndef WIDTH
`define WIDTH 16
`endif

module tb_stack_controller;

    localparam int DEPTH = 4;
    localparam int CAP   = 16;

    logic              clock = 1'b0;
    logic              active_low_reset;
    logic              op_valid;
    logic [1:0]        op_code;
    logic [`WIDTH-1:0] push_data;
    logic              op_ready;
    logic              error_clear;
    logic [`WIDTH-1:0] top_data;
    logic [DEPTH:0]    depth_count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic [DEPTH-1:0]  mem_read_address;
    logic [`WIDTH-1:0] mem_read_data;
    logic              mem_write_enable;
    logic [DEPTH-1:0]  mem_write_address;
    logic [`WIDTH-1:0] mem_write_data;

    stack_controller #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .active_low_reset(active_low_reset),
        .op_valid(op_valid),
        .op_code(op_code),
        .push_data(push_data),
        .op_ready(op_ready),
        .error_clear(error_clear),
        .top_data(top_data),
        .depth_count(depth_count),
        .empty(empty),
        .full(full),
        .overflow(overflow),
        .underflow(underflow),
        .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data)
    );

    always #5 clock = ~clock;

    // External stack RAM: synchronous write, combinational read.
    logic [`WIDTH-1:0] ram [0:CAP-1];
    always @(posedge clock) if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
    assign mem_read_data = ram[mem_read_address];

    // Reference model: a plain queue with the top at the back.
    logic [`WIDTH-1:0] stk [$];
    bit mFault, mOvf, mUnf;
    int errors = 0;
    int checks = 0;

    function automatic bit expWe();
        return active_low_reset && !mFault && op_valid &&
               ((op_code == 2'b01 && stk.size() < CAP) || (op_code == 2'b11 && stk.size() > 0));
    endfunction

    function automatic logic [DEPTH-1:0] expWAddr();
        return (op_code == 2'b01) ? DEPTH'(stk.size()) : DEPTH'(stk.size() - 1);
    endfunction

    function automatic logic [`WIDTH-1:0] expTop();
        return (stk.size() == 0) ? '0 : stk[stk.size()-1];
    endfunction

    task automatic drive(input bit v, input logic [1:0] code, input logic [`WIDTH-1:0] d, input bit clr);
        op_valid    = v;
        op_code     = code;
        push_data   = d;
        error_clear = clr;
        #1;
    endtask

    task automatic tick();
        if (!active_low_reset) begin
            stk.delete();
            mFault = 0; mOvf = 0; mUnf = 0;
        end else if (mFault) begin
            if (error_clear) begin mFault = 0; mOvf = 0; mUnf = 0; end
        end else if (op_valid) begin
            case (op_code)
                2'b01: if (stk.size() == CAP) begin mOvf = 1; mFault = 1; end
                       else stk.push_back(push_data);
                2'b10: if (stk.size() == 0) begin mUnf = 1; mFault = 1; end
                       else void'(stk.pop_back());
                2'b11: if (stk.size() == 0) begin mUnf = 1; mFault = 1; end
                       else stk[stk.size()-1] = push_data;
                default: ;
            endcase
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        active_low_reset = 1'b0;
        drive(0, 2'b00, '0, 0);
        tick();
        checks++; if (depth_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_depth: got %0d expected 0", depth_count); end
        checks++; if ({empty, full, op_ready} !== 3'b101) begin errors++; $display("[TB] FAIL reset_empty_full_ready: got %b expected 101", {empty, full, op_ready}); end
        checks++; if ({overflow, underflow, mem_write_enable} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags_we: got %b expected 000", {overflow, underflow, mem_write_enable}); end
        checks++; if (top_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_top: got %h expected 0000", top_data); end
        active_low_reset = 1'b1;
        #1;
    endtask

    task automatic test_push_replace_pop();
        drive(1, 2'b01, 16'h1111, 0);
        checks++; if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 4'd0, 16'h1111}) begin errors++; $display("[TB] FAIL push1_write: got %b/%0d/%h expected 1/0/1111", mem_write_enable, mem_write_address, mem_write_data); end
        tick();
        drive(1, 2'b01, 16'h2222, 0);
        checks++; if ({mem_write_enable, mem_write_address} !== {1'b1, 4'd1}) begin errors++; $display("[TB] FAIL push2_write: got %b/%0d expected 1/1", mem_write_enable, mem_write_address); end
        tick();
        drive(0, 2'b00, '0, 0);
        checks++; if (depth_count !== 5'd2 || top_data !== 16'h2222) begin errors++; $display("[TB] FAIL push2_state: got %0d/%h expected 2/2222", depth_count, top_data); end
        drive(1, 2'b11, 16'hABCD, 0);
        checks++; if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 4'd1, 16'hABCD}) begin errors++; $display("[TB] FAIL replace_write: got %b/%0d/%h expected 1/1/abcd", mem_write_enable, mem_write_address, mem_write_data); end
        tick();
        drive(1, 2'b10, 16'hFFFF, 0);
        checks++; if (depth_count !== 5'd2 || top_data !== 16'hABCD) begin errors++; $display("[TB] FAIL replace_state: got %0d/%h expected 2/abcd", depth_count, top_data); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL pop_no_write: got %b expected 0", mem_write_enable); end
        tick();
        drive(0, 2'b00, '0, 0);
        checks++; if (depth_count !== 5'd1 || top_data !== 16'h1111) begin errors++; $display("[TB] FAIL pop_state: got %0d/%h expected 1/1111", depth_count, top_data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < CAP - 1; i++) begin
            drive(1, 2'b01, 16'h3000 + 16'(i), 0);
            tick();
        end
        drive(1, 2'b01, 16'hDEAD, 0);
        checks++; if ({full, depth_count} !== {1'b1, 5'd16}) begin errors++; $display("[TB] FAIL full_state: got %b/%0d expected 1/16", full, depth_count); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL overflow_no_write: got %b expected 0", mem_write_enable); end
        tick();
        drive(1, 2'b10, '0, 0);
        checks++; if ({overflow, op_ready} !== 2'b10) begin errors++; $display("[TB] FAIL overflow_fault: got %b expected 10", {overflow, op_ready}); end
        tick();
        drive(1, 2'b10, '0, 1);
        checks++; if (depth_count !== 5'd16) begin errors++; $display("[TB] FAIL fault_frozen: got %0d expected 16", depth_count); end
        tick();
        drive(1, 2'b11, 16'h5A5A, 0);
        checks++; if ({op_ready, overflow, depth_count} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("[TB] FAIL overflow_clear: got %b/%b/%0d expected 1/0/16", op_ready, overflow, depth_count); end
        checks++; if ({mem_write_enable, mem_write_address} !== {1'b1, 4'd15}) begin errors++; $display("[TB] FAIL full_replace_write: got %b/%0d expected 1/15", mem_write_enable, mem_write_address); end
        tick();
        drive(0, 2'b00, '0, 0);
        checks++; if ({top_data, overflow} !== {16'h5A5A, 1'b0}) begin errors++; $display("[TB] FAIL full_replace_state: got %h/%b expected 5a5a/0", top_data, overflow); end
    endtask

    task automatic test_underflow();
        active_low_reset = 1'b0;
        tick();
        active_low_reset = 1'b1;
        drive(1, 2'b10, '0, 0);
        tick();
        drive(1, 2'b01, 16'h7777, 0);
        checks++; if ({underflow, op_ready, depth_count} !== {1'b1, 1'b0, 5'd0}) begin errors++; $display("[TB] FAIL underflow_fault: got %b/%b/%0d expected 1/0/0", underflow, op_ready, depth_count); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL fault_no_write: got %b expected 0", mem_write_enable); end
        tick();
        drive(1, 2'b01, 16'h7777, 1);
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL clear_cycle_no_accept: got %b expected 0", mem_write_enable); end
        tick();
        drive(0, 2'b00, '0, 0);
        checks++; if ({op_ready, underflow, depth_count} !== {1'b1, 1'b0, 5'd0}) begin errors++; $display("[TB] FAIL underflow_clear: got %b/%b/%0d expected 1/0/0", op_ready, underflow, depth_count); end
    endtask

    task automatic test_reset_mid_op();
        drive(1, 2'b01, 16'h4444, 0);
        tick();
        drive(1, 2'b01, 16'h5555, 0);
        active_low_reset = 1'b0;
        #1;
        checks++; if ({mem_write_enable, depth_count} !== {1'b0, 5'd0}) begin errors++; $display("[TB] FAIL reset_abort: got %b/%0d expected 0/0", mem_write_enable, depth_count); end
        tick();
        active_low_reset = 1'b1;
        drive(0, 2'b00, '0, 0);
        checks++; if ({empty, overflow, underflow, depth_count, top_data} !== {3'b100, 5'd0, 16'h0}) begin errors++; $display("[TB] FAIL reset_after: got %b%b%b/%0d/%h expected 100/0/0000", empty, overflow, underflow, depth_count, top_data); end
    endtask

    task automatic test_random();
        int r;
        logic [1:0] code;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            code = (r < 45) ? 2'b01 : (r < 70) ? 2'b10 : (r < 88) ? 2'b11 : 2'b00;
            drive($urandom_range(0, 3) != 0, code, 16'($urandom), $urandom_range(0, 3) == 0);
            checks++; if (op_ready !== !mFault) begin errors++; $display("[TB] FAIL rnd_ready: got %b expected %b", op_ready, !mFault); end
            checks++; if (mem_write_enable !== expWe()) begin errors++; $display("[TB] FAIL rnd_we: got %b expected %b", mem_write_enable, expWe()); end
            if (expWe()) begin
                checks++; if ({mem_write_address, mem_write_data} !== {expWAddr(), push_data}) begin errors++; $display("[TB] FAIL rnd_waddr: got %0d/%h expected %0d/%h", mem_write_address, mem_write_data, expWAddr(), push_data); end
            end
            checks++; if (depth_count !== 5'(stk.size())) begin errors++; $display("[TB] FAIL rnd_depth: got %0d expected %0d", depth_count, stk.size()); end
            checks++; if ({empty, full} !== {stk.size() == 0, stk.size() == CAP}) begin errors++; $display("[TB] FAIL rnd_empty_full: got %b%b expected %b%b", empty, full, stk.size() == 0, stk.size() == CAP); end
            checks++; if ({overflow, underflow} !== {mOvf, mUnf}) begin errors++; $display("[TB] FAIL rnd_flags: got %b%b expected %b%b", overflow, underflow, mOvf, mUnf); end
            checks++; if (mem_read_address !== DEPTH'(stk.size() - 1)) begin errors++; $display("[TB] FAIL rnd_raddr: got %0d expected %0d", mem_read_address, DEPTH'(stk.size() - 1)); end
            checks++; if (top_data !== expTop()) begin errors++; $display("[TB] FAIL rnd_top: got %h expected %h", top_data, expTop()); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < CAP; i++) ram[i] = '0;
        active_low_reset = 1'b0;
        drive(0, 2'b00, '0, 0);
        @(negedge clock);
        test_reset();
        test_push_replace_pop();
        test_overflow();
        test_underflow();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of stack RAM address bits; capacity is 2**DEPTH entries.
REQ-002 SHALL use data width `WIDTH (16) from common.h for all data ports.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, in that port order:
- clock  input  1  rising-edge clock.
- active_low_reset  input  1  asynchronous active-low reset.
REQ-004 SHALL provide the remaining ports exactly as follows:
- op_valid  input  1  command present.
- op_code  input  2  00 nop, 01 push, 10 pop, 11 replace (pop+push).
- push_data  input  `WIDTH  data for push/replace.
- op_ready  output  1  command accepted this cycle when op_valid=1.
- error_clear  input  1  leave FAULT, clear error flags.
- top_data  output  `WIDTH  current top-of-stack value.
- depth_count  output  DEPTH+1  number of valid entries.
- empty  output  1  depth_count==0.
- full  output  1  depth_count==2**DEPTH.
- overflow  output  1  sticky, push attempted while full.
- underflow  output  1  sticky, pop/replace attempted while empty.
- mem_read_address  output  DEPTH  to stack RAM read port.
- mem_read_data  input  `WIDTH  combinational read data from stack RAM.
- mem_write_enable  output  1  to stack RAM write port.
- mem_write_address  output  DEPTH  to stack RAM write port.
- mem_write_data  output  `WIDTH  to stack RAM write port.

Function
REQ-005 SHALL implement two states: RUN and FAULT; op_ready=1 in RUN, 0 in FAULT.
REQ-006 SHALL treat a command as accepted when op_valid & op_ready; non-accepted cycles change no state and assert no write.
REQ-007 Push accepted, not full: mem_write_enable=1 same cycle, mem_write_address=depth_count[DEPTH-1:0], mem_write_data=push_data; depth_count+1 at next edge.
REQ-008 Pop accepted, not empty: no write; depth_count-1 at next edge.
REQ-009 Replace accepted, not empty: mem_write_enable=1, mem_write_address=depth_count-1 (low DEPTH bits), mem_write_data=push_data; depth_count unchanged; legal when full.
REQ-010 Nop accepted: no write, no state change.
REQ-011 Push while full: no write, depth_count unchanged, overflow<=1, state<=FAULT.
REQ-012 Pop or replace while empty: no write, depth_count unchanged, underflow<=1, state<=FAULT.
REQ-013 mem_read_address SHALL be (depth_count-1) truncated to DEPTH bits at all times (wraps to all-ones when empty).
REQ-014 top_data SHALL equal mem_read_data when not empty, 0 when empty; a push/replace value appears on top_data the cycle after acceptance (1-cycle latency).
REQ-015 In FAULT: no writes, depth_count frozen, flags held; error_clear=1 at an edge returns to RUN with overflow=underflow=0, depth_count preserved.
REQ-016 error_clear in RUN SHALL have no effect; op_valid in the same cycle as error_clear in FAULT SHALL not be accepted.
REQ-017 depth_count SHALL never exceed 2**DEPTH nor go below 0; empty/full decode combinationally from depth_count.
REQ-018 At most one RAM write per cycle; mem_write_enable SHALL be 0 except in cases REQ-007 and REQ-009.

Reset
REQ-019 On active_low_reset=0 (asynchronous): state=RUN, depth_count=0, overflow=0, underflow=0; thus empty=1, full=0, op_ready=1, top_data=0, mem_write_enable=0.
REQ-020 Reset asserted mid-operation SHALL abort any command immediately; RAM contents are not cleared and are not visible afterwards (empty).

Verification
REQ-021 Reset, then push 0x1111, 0x2222 -> writes at addr 0,1; depth_count=2; top_data=0x2222 next cycle.
REQ-022 From depth 2, replace 0xABCD -> write addr 1, depth_count=2, top_data=0xABCD; then pop -> top_data=0x1111, depth_count=1.
REQ-023 DEPTH=4: 16 pushes -> full=1, depth_count=16; 17th push -> no write, overflow=1, op_ready=0; error_clear -> RUN, overflow=0, depth_count=16.
REQ-024 Empty, pop -> underflow=1, FAULT, depth_count=0; ops ignored while FAULT; error_clear -> op_ready=1.
REQ-025 Full stack, replace 0x5A5A -> write addr 15, no overflow, top_data=0x5A5A.
REQ-026 Push accepted with reset asserted in the same cycle -> depth_count=0, empty=1, no error flags after reset.
